// File: rtl/ec_point_add_double.sv
// Affine short-Weierstrass point add/double over GF(p) with a private modular multiplier and a binary-Euclid inverse.
// Optional operand range check is enabled by defining EC_RANGE_CHECK_EN.

module ec_mod_mul #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] p,
    output logic         done,
    output logic [N-1:0] r
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  a_q, b_q, acc;
    logic [CW-1:0] cnt;
    logic          run;
    logic [N+1:0]  t;

    // MSB-first interleaved multiply: 2*acc + bit*a stays below 3p, so two subtractions reduce it.
    // NOTE: every combinational variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        t = {1'b0, acc, 1'b0} + (b_q[N-1] ? {2'b00, a_q} : '0);
        if (t >= {2'b00, p}) t = t - {2'b00, p};
        if (t >= {2'b00, p}) t = t - {2'b00, p};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                cnt <= CW'(N);
                run <= 1'b1;
            end else if (run) begin
                acc <= t[N-1:0];
                b_q <= b_q << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign r = acc;
endmodule

module ec_mod_inv #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] p,
    output logic         done,
    output logic [N-1:0] r
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] u, v, c1, c2;
    logic         run;

    function automatic logic [N-1:0] half_mod(input logic [N-1:0] x, input logic [N-1:0] m);
        logic [N:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[N:1];
    endfunction

    // Result is below m, so wrapping in N bits is exact.
    function automatic logic [N-1:0] sub_mod(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] m);
        return x - y + ((x >= y) ? '0 : m);
    endfunction

    // Invariants c1*a == u and c2*a == v (mod p); a zero operand ends with result 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            u    <= '0;
            v    <= '0;
            c1   <= '0;
            c2   <= '0;
            r    <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                u   <= a;
                v   <= p;
                c1  <= ONE;
                c2  <= '0;
                run <= 1'b1;
            end else if (run) begin
                if (u == ONE || v == ONE || u == '0 || v == '0) begin
                    r    <= (u == ONE) ? c1 : (v == ONE) ? c2 : '0;
                    run  <= 1'b0;
                    done <= 1'b1;
                end else if (!u[0]) begin
                    u  <= u >> 1;
                    c1 <= half_mod(c1, p);
                end else if (!v[0]) begin
                    v  <= v >> 1;
                    c2 <= half_mod(c2, p);
                end else if (u >= v) begin
                    u  <= u - v;
                    c1 <= sub_mod(c1, c2, p);
                end else begin
                    v  <= v - u;
                    c2 <= sub_mod(c2, c1, p);
                end
            end
        end
    end
endmodule

module ec_point_add_double #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    input  logic         inf1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] y2,
    input  logic         inf2,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic         inf3,
    output logic         busy,
    output logic         done,
    output logic         err
);
    typedef enum logic [3:0] {
        IDLE, CLASSIFY, TRIVIAL, DBL_SQ, ADD_SUB, INV, LAMBDA, LAMBDA_SQ, X3, Y3_MUL, Y3, DONE
    } state_t;

    state_t       state, state_n;
    logic [N-1:0] lp, la, lx1, ly1, lx2, ly2;
    logic         li1, li2;
    logic [N-1:0] num, den, dinv, lam, prod, rx3;
    logic         issued, range_bad, is_pair, is_dbl;
    logic         mul_start, mul_done, inv_start, inv_done;
    logic [N-1:0] mul_a, mul_b, mul_r, inv_r;

    function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] m);
        logic [N+1:0] s;
        s = {2'b00, x} + {2'b00, y};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] m);
        logic [N+1:0] s;
        s = {2'b00, x} + {2'b00, m} - {2'b00, y};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        return s[N-1:0];
    endfunction

    assign is_pair = (lx1 == lx2) && (mod_add(ly1, ly2, lp) == '0);
    assign is_dbl  = (lx1 == lx2) && (ly1 == ly2);
    assign busy    = !(state inside {IDLE, TRIVIAL, DONE});
    assign done    = (state == TRIVIAL) || (state == DONE);

`ifdef EC_RANGE_CHECK_EN
    logic err_q;
    assign range_bad = (la >= lp) || (!li1 && (lx1 >= lp || ly1 >= lp))
                                  || (!li2 && (lx2 >= lp || ly2 >= lp));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         err_q <= 1'b0;
        else if (state == IDLE && start)      err_q <= 1'b0;
        else if (state == CLASSIFY && range_bad) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign range_bad = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Each sub-unit step pulses its start once, on the first cycle of the step.
    always_comb begin
        state_n   = state;
        mul_start = 1'b0;
        inv_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            IDLE:     if (start) state_n = CLASSIFY;
            CLASSIFY: begin
                if (range_bad)                  state_n = DONE;
                else if (li1 || li2 || is_pair) state_n = TRIVIAL;
                else if (is_dbl)                state_n = DBL_SQ;
                else                            state_n = ADD_SUB;
            end
            TRIVIAL:  state_n = IDLE;
            DBL_SQ: begin
                mul_start = !issued;
                mul_a     = lx1;
                mul_b     = lx1;
                if (mul_done) state_n = INV;
            end
            ADD_SUB:  state_n = INV;
            INV: begin
                inv_start = !issued;
                if (inv_done) state_n = LAMBDA;
            end
            LAMBDA: begin
                mul_start = !issued;
                mul_a     = num;
                mul_b     = dinv;
                if (mul_done) state_n = LAMBDA_SQ;
            end
            LAMBDA_SQ: begin
                mul_start = !issued;
                mul_a     = lam;
                mul_b     = lam;
                if (mul_done) state_n = X3;
            end
            X3:       state_n = Y3_MUL;
            Y3_MUL: begin
                mul_start = !issued;
                mul_a     = lam;
                mul_b     = mod_sub(lx1, rx3, lp);
                if (mul_done) state_n = Y3;
            end
            Y3:       state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {lp, la, lx1, ly1, lx2, ly2} <= '0;
            {li1, li2}                   <= '0;
            {num, den, dinv, lam, prod, rx3} <= '0;
            {x3, y3}                     <= '0;
            inf3                         <= 1'b0;
            issued                       <= 1'b0;
        end else begin
            if (state_n != state)          issued <= 1'b0;
            else if (mul_start || inv_start) issued <= 1'b1;

            case (state)
                IDLE: if (start) begin
                    lp  <= p;
                    la  <= a;
                    lx1 <= x1;
                    ly1 <= y1;
                    li1 <= inf1;
                    lx2 <= x2;
                    ly2 <= y2;
                    li2 <= inf2;
                end
                CLASSIFY: begin
                    if (range_bad) begin
                        {x3, y3} <= '0;
                        inf3     <= 1'b0;
                    end else if (li1) begin
                        x3   <= li2 ? '0 : lx2;
                        y3   <= li2 ? '0 : ly2;
                        inf3 <= li2;
                    end else if (li2) begin
                        x3   <= lx1;
                        y3   <= ly1;
                        inf3 <= 1'b0;
                    end else if (is_pair) begin
                        {x3, y3} <= '0;
                        inf3     <= 1'b1;
                    end
                end
                DBL_SQ: if (mul_done) begin
                    num <= mod_add(mod_add(mod_add(mul_r, mul_r, lp), mul_r, lp), la, lp);
                    den <= mod_add(ly1, ly1, lp);
                end
                ADD_SUB: begin
                    num <= mod_sub(ly2, ly1, lp);
                    den <= mod_sub(lx2, lx1, lp);
                end
                INV:       if (inv_done) dinv <= inv_r;
                LAMBDA:    if (mul_done) lam  <= mul_r;
                LAMBDA_SQ: if (mul_done) prod <= mul_r;
                X3:        rx3 <= mod_sub(mod_sub(prod, lx1, lp), is_dbl ? lx1 : lx2, lp);
                Y3_MUL:    if (mul_done) prod <= mul_r;
                Y3: begin
                    x3   <= rx3;
                    y3   <= mod_sub(prod, ly1, lp);
                    inf3 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    ec_mod_mul #(.N(N)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .p       (lp),
        .done    (mul_done),
        .r       (mul_r)
    );

    ec_mod_inv #(.N(N)) u_inv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (inv_start),
        .a       (den),
        .p       (lp),
        .done    (inv_done),
        .r       (inv_r)
    );
endmodule

// File: tb/tb_ec_point_add_double.sv
// Scoreboard bench for ec_point_add_double at N=8: directed curve points plus random operands
// compared against a plain-arithmetic group-law model.

module tb_ec_point_add_double;
    localparam int N = 8;

    logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [N-1:0] p = '0, a = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic         inf1 = 1'b0, inf2 = 1'b0;
    logic [N-1:0] x3, y3;
    logic         inf3, busy, done, err;

    typedef struct {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         inf;
        logic         err;
        bit           chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0;

    ec_point_add_double #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .p(p), .a(a),
        .x1(x1), .y1(y1), .inf1(inf1), .x2(x2), .y2(y2), .inf2(inf2),
        .x3(x3), .y3(y3), .inf3(inf3), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic longint pow_mod(input longint b, input longint e, input longint m);
        longint r = 1;
        b = b % m;
        while (e > 0) begin
            if ((e & 1) != 0) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    // Group law R = P + Q written straight from the curve equations; p is prime here.
    function automatic exp_t ref_model(input longint pp, input longint aa,
                                       input longint px, input longint py, input bit pi,
                                       input longint qx, input longint qy, input bit qi);
        exp_t   e;
        longint lam, rx, ry;
        bit     bad;
        e = '{x: '0, y: '0, inf: 1'b0, err: 1'b0, chk: 1'b1};
        bad = (aa >= pp) || (!pi && (px >= pp || py >= pp)) || (!qi && (qx >= pp || qy >= pp));
        if (bad) begin
`ifdef EC_RANGE_CHECK_EN
            e.err = 1'b1;
`else
            e.chk = 1'b0;
`endif
            return e;
        end
        if (pi) begin
            e.inf = qi;
            e.x   = qi ? '0 : N'(qx);
            e.y   = qi ? '0 : N'(qy);
        end else if (qi) begin
            e.x = N'(px);
            e.y = N'(py);
        end else if (px == qx && (py + qy) % pp == 0) begin
            e.inf = 1'b1;
        end else begin
            if (px == qx && py == qy)
                lam = ((3 * px * px + aa) % pp) * pow_mod((2 * py) % pp, pp - 2, pp) % pp;
            else
                lam = ((qy - py + pp) % pp) * pow_mod((qx - px + pp) % pp, pp - 2, pp) % pp;
            rx  = (lam * lam + 2 * pp - px - qx) % pp;
            ry  = (lam * ((px - rx + pp) % pp) + pp - py) % pp;
            e.x = N'(rx);
            e.y = N'(ry);
        end
        return e;
    endfunction

    // Monitor: every done pulse consumes one expectation and must last exactly one cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, required no completion pending");
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk) begin
                        check("x3", x3, e.x);
                        check("y3", y3, e.y);
                        check("inf3", inf3, e.inf);
                    end
                    check("err", err, e.err);
                    check("busy_at_done", busy, 0);
                end
                @(negedge clk);
                check("done_pulse_width", done, 0);
            end
        end
    end

    task automatic scramble();
        p = N'($urandom); a = N'($urandom);
        x1 = N'($urandom); y1 = N'($urandom); inf1 = 1'($urandom);
        x2 = N'($urandom); y2 = N'($urandom); inf2 = 1'($urandom);
    endtask

    task automatic issue(input logic [N-1:0] pp, input logic [N-1:0] aa,
                         input logic [N-1:0] px, input logic [N-1:0] py, input logic pi,
                         input logic [N-1:0] qx, input logic [N-1:0] qy, input logic qi,
                         input bit push, output int t0);
        @(posedge clk); #1;
        p = pp; a = aa; x1 = px; y1 = py; inf1 = pi; x2 = qx; y2 = qy; inf2 = qi;
        start = 1'b1;
        if (push) exp_q.push_back(ref_model(pp, aa, px, py, pi, qx, qy, qi));
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: got no done in 500 cycles, required done");
        end
    endtask

    task automatic do_op(input logic [N-1:0] pp, input logic [N-1:0] aa,
                         input logic [N-1:0] px, input logic [N-1:0] py, input logic pi,
                         input logic [N-1:0] qx, input logic [N-1:0] qy, input logic qi,
                         output int lat);
        int t0;
        issue(pp, aa, px, py, pi, qx, qy, qi, 1'b1, t0);
        wait_done(t0, lat);
    endtask

    initial begin : stimulus
        int lat, t0, pr, ar, mode;
        int primes[5] = '{17, 97, 251, 239, 163};
        logic [N-1:0] rx1, ry1, rx2, ry2;
        logic ri1, ri2;

        #3;
        check("reset_x3", x3, 0);
        check("reset_y3", y3, 0);
        check("reset_inf3", inf3, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(17, 2, 5, 1, 0, 5, 1, 0, lat);            // doubling -> (6,3)
        do_op(17, 2, 5, 1, 0, 6, 3, 0, lat);            // addition -> (10,6)
        do_op(17, 2, 7, 6, 0, 7, 11, 0, lat);           // inverse pair -> infinity
        check("pair_latency", lat, 2);
        do_op(17, 2, 0, 0, 1, 3, 1, 0, lat);            // inf1 -> Q
        check("inf1_latency", lat, 2);
        do_op(17, 2, 0, 0, 1, 0, 0, 1, lat);            // both infinite
        do_op(17, 2, 17, 1, 0, 6, 3, 0, lat);           // x1 out of range
        do_op(17, 2, 5, 1, 0, 6, 3, 0, lat);            // err must clear again

        // A second start while busy must be ignored.
        issue(17, 2, 5, 1, 0, 6, 3, 0, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1;
        p = 17; a = 2; x1 = 7; y1 = 6; inf1 = 0; x2 = 7; y2 = 11; inf2 = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(t0, lat);

        // Reset in the middle of an operation aborts it with no completion.
        issue(17, 2, 5, 1, 0, 6, 3, 0, 1'b0, t0);
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_x3", x3, 0);
        check("abort_y3", y3, 0);
        check("abort_inf3", inf3, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(17, 2, 5, 1, 0, 6, 3, 0, lat);

        for (int i = 0; i < 40; i++) begin
            pr   = primes[$urandom_range(0, 4)];
            ar   = int'($urandom_range(0, pr - 1));
            mode = int'($urandom_range(0, 5));
            rx1  = N'($urandom_range(0, pr - 1));
            ry1  = N'($urandom_range(0, pr - 1));
            rx2  = N'($urandom_range(0, pr - 1));
            ry2  = N'($urandom_range(0, pr - 1));
            ri1  = 1'b0;
            ri2  = 1'b0;
            case (mode)
                0: if (rx2 == rx1) rx2 = N'((int'(rx1) + 1) % pr);
                1: begin rx2 = rx1; ry2 = ry1; end
                2: begin rx2 = rx1; ry2 = N'((pr - int'(ry1)) % pr); end
                3: ri1 = 1'b1;
                4: ri2 = 1'b1;
                default: begin ri1 = 1'b1; ri2 = 1'b1; end
            endcase
            do_op(N'(pr), N'(ar), rx1, ry1, ri1, rx2, ry2, ri2, lat);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ec_point_add_double.md
Name: ec_point_add_double

Overview:
Unified elliptic-curve point unit for short-Weierstrass curves y^2 = x^3 + a*x + b over GF(p), generalised in width N. It computes R = P + Q with start/done handshake and automatically selects the addition, doubling or point-at-infinity path. Affine coordinates with explicit infinity flags on inputs and outputs. Sits under the scalar-multiplication controller of the ECDSA datapath and drives one shared modular multiplier and one modular inverse, each with its own start/done handshake.

Parameters:
N, 256, field/coordinate width in bits; p, a and all coordinates are N bits.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; operands sampled in the same cycle; ignored while busy=1
p  in  N  field prime, odd, > 3
a  in  N  curve coefficient a, < p
x1, y1  in  N  point P coordinates
inf1  in  1  P is point at infinity (x1/y1 ignored)
x2, y2  in  N  point Q coordinates
inf2  in  1  Q is point at infinity
x3, y3  out  N  result coordinates; 0 when inf3=1
inf3  out  1  result is point at infinity
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse; outputs valid from this cycle
err  out  1  operand range error (see Optional Feature); 0 otherwise

Behaviour:
- Reset (async, reset_n=0): state IDLE; x3=y3=0, inf3=0, busy=0, done=0, err=0; sub-unit starts deasserted. Reset mid-operation aborts immediately; sub-unit results in flight are discarded.
- start accepted only in IDLE: latch p, a, x1, y1, inf1, x2, y2, inf2; busy=1 next cycle. start while busy has no effect.
- States: IDLE -> CLASSIFY -> {TRIVIAL | DBL_SQ | ADD_SUB} -> INV -> LAMBDA -> LAMBDA_SQ -> X3 -> Y3_MUL -> Y3 -> DONE -> IDLE.
- CLASSIFY, in priority order:
  1. inf1 -> R=Q (incl. inf3=inf2).
  2. inf2 -> R=P.
  3. x1==x2 and (y1+y2) mod p==0 -> R=infinity; covers the y1=y2=0 doubling case.
  4. x1==x2 and y1==y2 -> doubling.
  5. Otherwise -> addition.
  - Cases 1-3 go to TRIVIAL; done is asserted 2 cycles after the start cycle.
- Addition: num=(y2-y1) mod p, den=(x2-x1) mod p.
- Doubling: DBL_SQ multiplies x1*x1, then num=(3*x1^2+a) mod p, den=(2*y1) mod p.
- All modular add/sub use N+2-bit intermediates with at most two conditional subtractions of p. No "%" on full width.
- INV: den^-1. LAMBDA: num*den^-1. LAMBDA_SQ: lambda^2. X3: x3=(lambda^2 - xa - xb) mod p, with xb=x1 when doubling, x2 otherwise. Y3_MUL: lambda*(x1-x3). Y3: y3=(prod - y1) mod p.
- Each sub-unit wait holds until its done; the sub-unit start is a one-cycle pulse exactly once per step.
- Outputs update only at DONE, together with done=1 and busy=0, and hold until the next accepted start's DONE.
- Inputs may change freely after the start cycle without affecting the result.

Optional Feature:
EC_RANGE_CHECK_EN.
- Defined: in CLASSIFY, any non-infinity coordinate >= p, or a >= p, ends the operation. Next cycle: done=1, err=1, x3=y3=0, inf3=0. err clears at the next accepted start.
- Undefined: no check; err tied 0; out-of-range operands give undefined but terminating results.

Test Plan (N=8, p=17, a=2, curve y^2=x^3+2x+2, G=(5,1)):
- Doubling: P=Q=(5,1) -> x3=6, y3=3, inf3=0, single done pulse, busy low afterwards.
- Addition: P=(5,1), Q=(6,3) -> x3=10, y3=6.
- Inverse pair: P=(7,6), Q=(7,11) -> inf3=1, x3=y3=0, done 2 cycles after start.
- Infinity operand: inf1=1, Q=(3,1) -> x3=3, y3=1, inf3=0; separately inf1=inf2=1 -> inf3=1.
- Robustness: start re-pulsed while busy, then reset_n low mid-LAMBDA. Required response: extra start ignored; all outputs 0 immediately; a following (5,1)+(6,3) yields (10,6).
- EC_RANGE_CHECK_EN: x1=17 -> err=1, done=1, x3=y3=0. Without the macro, err stays 0.
